pipeline_ctrl: RTL and testbench

- Central sequencer for the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Produces each latch's en/flush pair and pc_en.
- Resolves, in fixed priority: data-memory wait, control redirect, load-use hazard and instruction-fetch miss.
- Owns the halt drain sequence and the sticky halt output to the system.

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_ctrl_hazard_unit.sv | 22 ++
 rtl/pipeline_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control slice.
//   regbits_t     : register-file index (5 bits)
//   word_t        : datapath word (32 bits)
//   pctrl_state_t : sequencer state (RUN, DWAIT, HALTED)
//   latch_ctrl_t  : enable/flush pair driven to one pipeline latch
package pipeline_ctrl_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational load-use detector.
// Ports:
//   idex_MemRead : EX-stage instruction is a load
//   idex_wsel    : EX-stage destination register
//   ifid_rs      : ID-stage source rs
//   ifid_rt      : ID-stage source rt
//   lu_stall     : ID-stage instruction consumes the load result next cycle
module hazard_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic     idex_MemRead,
  input  regbits_t idex_wsel,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     lu_stall
);

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign lu_stall = idex_MemRead & (idex_wsel != '0) &
                    ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB latches and the PC.
// Priority: dmem wait > halt > redirect > load-use > ifetch miss.
// Optional build macro PIPE_PERF_EN adds saturating performance counters;
// without it the counter ports are tied to zero.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   ihit, dhit          : ifetch / data access complete
//   exmem_dREN/dWEN     : MEM-stage memory request
//   exmem_halt          : MEM-stage halt instruction
//   redirect            : taken branch/jump resolved in MEM
//   idex_MemRead, idex_wsel, ifid_rs, ifid_rt : load-use inputs
//   pc_en, *_en, *_flush: PC and latch controls (combinational)
//   halt                : registered, sticky halt
//   stall_cnt, flush_cnt, dwait_cnt : performance counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_halt,
  input  logic             redirect,
  input  logic             idex_MemRead,
  input  regbits_t         idex_wsel,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] dwait_cnt
);

  pctrl_state_t state, state_nxt;
  latch_ctrl_t  ifid_c, idex_c, exmem_c, memwb_c;
  logic         lu_stall;
  logic         dwait_req;
  logic         resolve;
  logic         halt_take;
  logic         redirect_take;
  logic         halt_p1;

  hazard_unit u_hazard (
    .idex_MemRead (idex_MemRead),
    .idex_wsel    (idex_wsel),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .lu_stall     (lu_stall)
  );

  assign dwait_req = (exmem_dREN | exmem_dWEN) & ~dhit;

  // A cycle free of a data-memory wait evaluates the lower priorities,
  // including the cycle in which a pending access finally completes.
  assign resolve = ((state == RUN) & ~dwait_req) | ((state == DWAIT) & dhit);

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (dwait_req)       state_nxt = DWAIT;
        else if (exmem_halt) state_nxt = HALTED;
      end
      DWAIT: begin
        if (dhit) state_nxt = exmem_halt ? HALTED : RUN;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ifid_c        = '0;
    idex_c        = '0;
    exmem_c       = '0;
    memwb_c       = '0;
    pc_en         = 1'b0;
    halt_take     = 1'b0;
    redirect_take = 1'b0;
    if (RST) begin
      ifid_c.flush  = 1'b1;
      idex_c.flush  = 1'b1;
      exmem_c.flush = 1'b1;
      memwb_c.flush = 1'b1;
    end else if (resolve) begin
      ifid_c.en  = 1'b1;
      idex_c.en  = 1'b1;
      exmem_c.en = 1'b1;
      memwb_c.en = 1'b1;
      pc_en      = 1'b1;
      if (exmem_halt) begin
        // Only the halt itself drains into MEM/WB; everything behind it freezes.
        halt_take  = 1'b1;
        ifid_c.en  = 1'b0;
        idex_c.en  = 1'b0;
        exmem_c.en = 1'b0;
        pc_en      = 1'b0;
      end else if (redirect) begin
        redirect_take = 1'b1;
        ifid_c.flush  = 1'b1;
        idex_c.flush  = 1'b1;
        exmem_c.flush = 1'b1;
      end else if (lu_stall) begin
        pc_en        = 1'b0;
        ifid_c.en    = 1'b0;
        idex_c.flush = 1'b1;
      end else if (!ihit) begin
        pc_en        = 1'b0;
        ifid_c.flush = 1'b1;
      end
    end
  end

  assign ifid_en     = ifid_c.en;
  assign idex_en     = idex_c.en;
  assign exmem_en    = exmem_c.en;
  assign memwb_en    = memwb_c.en;
  assign ifid_flush  = ifid_c.flush;
  assign idex_flush  = idex_c.flush;
  assign exmem_flush = exmem_c.flush;
  assign memwb_flush = memwb_c.flush;

  // Halt register: set on the trigger edge, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)            halt_p1 <= 1'b0;
    else if (halt_take) halt_p1 <= 1'b1;
  end

  assign halt = halt_p1;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_p1, flush_p1, dwait_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Counters only move in RUN/DWAIT, so they freeze once HALTED.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_p1 <= '0;
      flush_p1 <= '0;
      dwait_p1 <= '0;
    end else begin
      if ((state != HALTED) && !pc_en) stall_p1 <= sat_inc(stall_p1);
      if (redirect_take)               flush_p1 <= sat_inc(flush_p1);
      if (state == DWAIT)              dwait_p1 <= sat_inc(dwait_p1);
    end
  end

  assign stall_cnt = stall_p1;
  assign flush_cnt = flush_p1;
  assign dwait_cnt = dwait_p1;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign dwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed steps followed by a random
// run, every cycle compared against a rule-level reference model.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, redirect;
  logic        idex_MemRead;
  logic [4:0]  idex_wsel, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [31:0] stall_cnt, flush_cnt, dwait_cnt;

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a pending data access, the halted condition, counters.
  logic        m_wait, m_halted;
  logic [31:0] m_stall, m_flush, m_dwait;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .dhit         (dhit),
    .exmem_dREN   (exmem_dREN),
    .exmem_dWEN   (exmem_dWEN),
    .exmem_halt   (exmem_halt),
    .redirect     (redirect),
    .idex_MemRead (idex_MemRead),
    .idex_wsel    (idex_wsel),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .halt         (halt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .dwait_cnt    (dwait_cnt)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
    exmem_halt = 1'b0; redirect = 1'b0; idex_MemRead = 1'b0;
    idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
  endtask

  // Compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    logic mem_block, go, lu, h, r, l, m;
    logic e_pc, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en;
    @(negedge CLK);
    mem_block = m_wait ? !dhit : ((exmem_dREN || exmem_dWEN) && !dhit);
    go = !RST && !m_halted && !mem_block;
    lu = idex_MemRead && (idex_wsel != 5'd0) &&
         ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
    h = go && exmem_halt;
    r = go && !h && redirect;
    l = go && !h && !r && lu;
    m = go && !h && !r && !l && !ihit;
    e_pc       = go && !h && !l && !m;
    e_ifid_en  = go && !h && !l;
    e_idex_en  = go && !h;
    e_exmem_en = go && !h;
    e_memwb_en = go;
    check_bit("pc_en",       pc_en,       e_pc);
    check_bit("ifid_en",     ifid_en,     e_ifid_en);
    check_bit("idex_en",     idex_en,     e_idex_en);
    check_bit("exmem_en",    exmem_en,    e_exmem_en);
    check_bit("memwb_en",    memwb_en,    e_memwb_en);
    check_bit("ifid_flush",  ifid_flush,  RST || r || m);
    check_bit("idex_flush",  idex_flush,  RST || r || l);
    check_bit("exmem_flush", exmem_flush, RST || r);
    check_bit("memwb_flush", memwb_flush, RST);
    check_bit("halt",        halt,        m_halted);
    check_cnt("stall_cnt",   stall_cnt,   PERF ? m_stall : 32'd0);
    check_cnt("flush_cnt",   flush_cnt,   PERF ? m_flush : 32'd0);
    check_cnt("dwait_cnt",   dwait_cnt,   PERF ? m_dwait : 32'd0);
    @(posedge CLK);
    if (RST) begin
      m_wait = 1'b0; m_halted = 1'b0;
      m_stall = '0; m_flush = '0; m_dwait = '0;
    end else if (!m_halted) begin
      if (!e_pc)  m_stall = sat1(m_stall);
      if (r)      m_flush = sat1(m_flush);
      if (m_wait) m_dwait = sat1(m_dwait);
      m_wait = mem_block;
      if (h) m_halted = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] dw0;
    m_wait = 1'b0; m_halted = 1'b0;
    m_stall = '0; m_flush = '0; m_dwait = '0;
    idle();
    RST = 1'b1;
    cycle();
    cycle();
    RST = 1'b0;
    cycle();

    // Load-use: one bubble, then the bubble itself has left EX.
    idex_MemRead = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8;
    cycle();
    idex_MemRead = 1'b0;
    cycle();
    // Load into register 0 never stalls.
    idex_MemRead = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0;
    cycle();
    idle();

    // Data memory wait: three waiting cycles, then completion.
    dw0 = dwait_cnt;
    exmem_dREN = 1'b1; dhit = 1'b0;
    cycle(); cycle(); cycle();
    dhit = 1'b1;
    cycle();
    idle();
    cycle();
    check_cnt("dwait_delta", dwait_cnt - dw0, PERF ? 32'd3 : 32'd0);

    // Redirect together with load-use: redirect wins.
    redirect = 1'b1; idex_MemRead = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8;
    cycle();
    idle();

    // Ifetch miss on its own.
    ihit = 1'b0;
    cycle();
    idle();

    // Request satisfied in the same cycle: no wait.
    exmem_dWEN = 1'b1; dhit = 1'b1;
    cycle();
    idle();

    // Reset while waiting on data memory.
    exmem_dREN = 1'b1; dhit = 1'b0;
    cycle(); cycle();
    RST = 1'b1;
    cycle();
    RST = 1'b0; idle();
    cycle();

    // Random traffic with occasional halts and resets.
    for (int i = 0; i < 1500; i++) begin
      RST          = ($urandom_range(0, 63) == 0);
      ihit         = ($urandom_range(0, 3) != 0);
      dhit         = $urandom_range(0, 1) == 1;
      exmem_dREN   = ($urandom_range(0, 3) == 0);
      exmem_dWEN   = ($urandom_range(0, 5) == 0);
      exmem_halt   = ($urandom_range(0, 31) == 0);
      redirect     = ($urandom_range(0, 7) == 0);
      idex_MemRead = $urandom_range(0, 1) == 1;
      idex_wsel    = 5'($urandom_range(0, 3));
      ifid_rs      = 5'($urandom_range(0, 3));
      ifid_rt      = 5'($urandom_range(0, 3));
      cycle();
    end

    // Halt drain, then stay halted despite activity.
    RST = 1'b1; idle();
    cycle();
    RST = 1'b0;
    cycle();
    exmem_halt = 1'b1; dhit = 1'b1;
    cycle();
    exmem_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit     = i[0];
      redirect = ~i[0];
      cycle();
    end
    check_bit("halt_sticky", halt, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
